// File: rtl/thermal_pkg.sv
// Shared types and default thresholds for the thermal fan controller.
package thermal_pkg;

  typedef enum logic [1:0] {
    FAN_LOW = 2'd1,
    FAN_MED = 2'd2,
    FAN_MAX = 2'd3
  } fan_level_t;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_MED,
    ST_MAX,
    ST_ALARM
  } therm_state_t;

  localparam int DEF_TEMP_W    = 8;
  localparam int DEF_AVG_LOG2  = 2;
  localparam int DEF_T_MED_ON  = 60;
  localparam int DEF_T_MED_OFF = 55;
  localparam int DEF_T_MAX_ON  = 80;
  localparam int DEF_T_MAX_OFF = 72;
  localparam int DEF_T_ALARM   = 95;
  localparam int DEF_DWELL     = 16;

  function automatic fan_level_t state_level(therm_state_t s);
    case (s)
      ST_LOW:  return FAN_LOW;
      ST_MED:  return FAN_MED;
      default: return FAN_MAX;
    endcase
  endfunction

endpackage

// File: rtl/temp_averager.sv
// Block averager: sums 2^AVG_LOG2 accepted samples, publishes the truncated mean.
module temp_averager
  import thermal_pkg::*;
#(
  parameter int TEMP_W   = DEF_TEMP_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  output logic              avg_valid,
  output logic [TEMP_W-1:0] avg_temp
);

  localparam int ACC_W = TEMP_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                avg_valid_q, avg_valid_d;
  logic [TEMP_W-1:0]   avg_temp_q, avg_temp_d;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_valid_d = 1'b0;
    avg_temp_d  = avg_temp_q;
    sum         = acc_q + ACC_W'(temp);
    if (temp_valid) begin
      cnt_d = cnt_q + AVG_LOG2'(1);
      if (&cnt_q) begin
        // last sample of the window: the counter wraps on its own
        avg_temp_d  = TEMP_W'(sum >> AVG_LOG2);
        avg_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_temp_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_valid_q <= avg_valid_d;
      avg_temp_q  <= avg_temp_d;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_temp  = avg_temp_q;

endmodule

// File: rtl/thermal_fan_ctrl.sv
// Fan level selection from windowed temperature averages, with hysteresis,
// dwell-gated downward steps and a sticky over-temperature alarm.
module thermal_fan_ctrl
  import thermal_pkg::*;
#(
  parameter int TEMP_W    = DEF_TEMP_W,
  parameter int AVG_LOG2  = DEF_AVG_LOG2,
  parameter int T_MED_ON  = DEF_T_MED_ON,
  parameter int T_MED_OFF = DEF_T_MED_OFF,
  parameter int T_MAX_ON  = DEF_T_MAX_ON,
  parameter int T_MAX_OFF = DEF_T_MAX_OFF,
  parameter int T_ALARM   = DEF_T_ALARM,
  parameter int DWELL     = DEF_DWELL
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              in_use,
  output logic [1:0]        fan_speed,
  output logic              avg_valid,
  output logic [TEMP_W-1:0] avg_temp,
  output logic              fan_change,
  output logic              alarm
);

  localparam int DW_W = $clog2(DWELL + 1);

  therm_state_t state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic fan_change_q, fan_change_d;
  logic alarm_q, alarm_d;
  logic down_ok;

  temp_averager #(
    .TEMP_W  (TEMP_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk       (CLK),
    .rst       (RST),
    .temp_valid(temp_valid),
    .temp      (temp),
    .avg_valid (avg_valid),
    .avg_temp  (avg_temp)
  );

  always_comb begin
    state_d = state_q;
    down_ok = !in_use || (dwell_q >= DW_W'(DWELL));
    if (avg_valid) begin
      if (state_q != ST_ALARM && avg_temp >= TEMP_W'(T_ALARM)) begin
        state_d = ST_ALARM;
      end else if (state_q == ST_ALARM) begin
        // alarm exit does not move the fan, so dwell does not gate it
        if (avg_temp < TEMP_W'(T_MAX_OFF)) state_d = ST_MAX;
      end else if (avg_temp >= TEMP_W'(T_MAX_ON)) begin
        state_d = ST_MAX;
      end else begin
        case (state_q)
          ST_LOW: if (avg_temp >= TEMP_W'(T_MED_ON)) state_d = ST_MED;
          ST_MED: if (avg_temp < TEMP_W'(T_MED_OFF) && down_ok) state_d = ST_LOW;
          ST_MAX: if (avg_temp < TEMP_W'(T_MAX_OFF) && down_ok) state_d = ST_MED;
          default: state_d = state_q;
        endcase
      end
    end
    fan_change_d = state_level(state_d) != state_level(state_q);
    alarm_d      = state_d == ST_ALARM;
    if (fan_change_d)                  dwell_d = '0;
    else if (dwell_q >= DW_W'(DWELL))  dwell_d = dwell_q;
    else                               dwell_d = dwell_q + DW_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_MAX;
      dwell_q      <= '0;
      fan_change_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      fan_change_q <= fan_change_d;
      alarm_q      <= alarm_d;
    end
  end

  assign fan_speed  = state_level(state_q);
  assign fan_change = fan_change_q;
  assign alarm      = alarm_q;

endmodule

// File: doc/thermal_fan_ctrl.md
# thermal_fan_ctrl

Closed-loop fan controller driving the `fan_speed` input of the `sensors` block. It consumes that block's temperature samples and averages them over a fixed window. A hysteresis state machine with dwell time selects the fan level, and a sticky over-temperature alarm is raised when needed. It sits between the sensor model and system monitoring logic.

## Interface
Parameters:
- `TEMP_W`, 8, temperature sample width (unsigned, °C)
- `AVG_LOG2`, 2, log2 of averaging window (window = 4 samples)
- `T_MED_ON`, 60, average at or above which LOW → MED
- `T_MED_OFF`, 55, average below which MED → LOW
- `T_MAX_ON`, 80, average at or above which fan goes to MAX
- `T_MAX_OFF`, 72, average below which MAX → MED, and below which the alarm clears
- `T_ALARM`, 95, average at or above which ALARM is entered
- `DWELL`, 16, minimum cycles at a level before a downward step while `in_use`=1

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1, system clock
- `RST` in 1, synchronous active-high reset
- `temp_valid` in 1, single-cycle strobe marking `temp` valid
- `temp` in TEMP_W, temperature sample
- `in_use` in 1, system load indication; selects the dwell rule
- `fan_speed` out 2, fan level: 1=LOW, 2=MED, 3=MAX (0 never driven)
- `avg_valid` out 1, one-cycle pulse when `avg_temp` updates
- `avg_temp` out TEMP_W, most recent window average
- `fan_change` out 1, one-cycle pulse in the cycle `fan_speed` takes a new value
- `alarm` out 1, sticky over-temperature flag

## Operation
- Averager:
  - Accumulator is TEMP_W+AVG_LOG2 bits, with no overflow.
  - A 2-bit sample counter wraps 3→0.
  - On the 2^AVG_LOG2-th accepted sample, `avg_temp` = (sum incl. this sample) >> AVG_LOG2, truncating. The accumulator clears and `avg_valid` pulses.
  - `temp_valid`=0 cycles are ignored, with no timeout.
- FSM states: LOW, MED, MAX, ALARM. `fan_speed` = 1/2/3/3 respectively. It is evaluated only on `avg_valid`.
- Upward moves ignore dwell:
  - From any state except ALARM, avg ≥ T_ALARM → ALARM and `alarm`=1.
  - Else avg ≥ T_MAX_ON → MAX.
  - Else, in LOW, avg ≥ T_MED_ON → MED.
- Downward moves step one level only:
  - MAX → MED when avg < T_MAX_OFF.
  - MED → LOW when avg < T_MED_OFF.
  - A downward move requires the dwell counter ≥ DWELL when `in_use`=1; when `in_use`=0 the dwell is not checked.
- ALARM → MAX when avg < T_MAX_OFF. `alarm` clears in the same cycle. ALARM never steps directly to MED.
- Dwell counter:
  - Resets to 0 on every `fan_speed` change and on reset.
  - Increments each cycle and saturates at DWELL.
- Averages falling between the ON and OFF thresholds of the current level hold the state.

## Timing
- Reset values: `fan_speed`=3 (state MAX, fail-safe), `avg_temp`=0, `avg_valid`=0, `fan_change`=0, `alarm`=0, accumulator=0, sample counter=0, dwell=0.
- Latency:
  - The last window sample with `temp_valid` in cycle N gives `avg_valid`/`avg_temp` in cycle N+1.
  - `fan_speed`/`fan_change`/`alarm` update in cycle N+2.
- `temp_valid` asserted during the reset cycle is discarded.
- Reset mid-window discards the partial sum. The next window starts from the first post-reset sample.
- Back-to-back `temp_valid` every cycle is supported. Windows abut with no dropped sample.
- `fan_change` never pulses when the evaluated next state equals the current state.

## Structure
- Package `thermal_pkg`:
  - `fan_level_t` enum with FAN_LOW=2'd1, FAN_MED=2'd2, FAN_MAX=2'd3.
  - `therm_state_t` enum with LOW/MED/MAX/ALARM.
  - Default threshold constants.
- One sub-module, `temp_averager`, containing the accumulator, sample counter and `avg_valid`/`avg_temp` registers. The FSM and dwell counter live in the top.

## Test plan
- Reset: hold `RST` 3 cycles with `temp_valid`=1 → after release `fan_speed`=3, `alarm`=0, `avg_temp`=0, and no `avg_valid` until 4 new samples arrive.
- Averaging and truncation:
  - Samples 40,44,48,53 → `avg_temp`=46 one cycle after the 4th sample.
  - That average then steps MAX→MED→LOW over successive windows, given `in_use`=0.
- Hysteresis, starting in LOW:
  - Windows averaging 60 → MED at N+2 with a single `fan_change` pulse.
  - Average 57 → stays MED.
  - Average 54 → LOW.
- Dwell, with `in_use`=1 in MAX:
  - An average of 70 arriving 10 cycles after entering MAX → no change.
  - The next window of 70 after ≥16 cycles → MED.
  - The same first case repeated with `in_use`=0 → immediate MED.
- Alarm:
  - Average 96 from LOW → `fan_speed`=3, `alarm`=1.
  - Average 75 → remains ALARM.
  - Average 70 → MAX with `alarm`=0.
- Mid-window reset: 2 samples of 200, `RST`, then 4 samples of 30 → `avg_temp`=30 and state steps down from MAX.
